// File: rtl/univ_shift_reg.sv
// Universal shift register: hold/shift/rotate/load/clear plus an auto-serialise FSM (LSB first).
// Optional registered parity output of q enabled by defining SHREG_PARITY_EN.
module univ_shift_reg #(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sin_msb,
    input  logic             sin_lsb,
    output logic [WIDTH-1:0] q,
    output logic             sout_lsb,
    output logic             sout_msb,
    output logic             busy,
    output logic             done
`ifdef SHREG_PARITY_EN
    ,
    output logic             parity
`endif
);

    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   q_q, q_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            q_q     <= RST_VAL;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        // done is a single-cycle pulse and drops on the next edge even when en is low
        done_d  = 1'b0;
        if (en) begin
            case (state_q)
                IDLE: begin
                    case (mode)
                        3'b000: q_d = q_q;
                        3'b001: q_d = {sin_msb, q_q[WIDTH-1:1]};
                        3'b010: q_d = {q_q[WIDTH-2:0], sin_lsb};
                        3'b011: q_d = {q_q[0], q_q[WIDTH-1:1]};
                        3'b100: q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
                        3'b101: q_d = d;
                        3'b110: begin
                            q_d     = d;
                            cnt_d   = '0;
                            busy_d  = 1'b1;
                            state_d = SHIFT;
                        end
                        default: q_d = '0;
                    endcase
                end
                SHIFT: begin
                    if (mode == 3'b111) begin
                        q_d     = '0;
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end else begin
                        q_d   = {sin_msb, q_q[WIDTH-1:1]};
                        cnt_d = cnt_q + CNT_W'(1);
                        // last bit has been presented for a full period; finish on this edge
                        if (cnt_q == CNT_W'(WIDTH - 1)) begin
                            cnt_d   = '0;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                            state_d = IDLE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

`ifdef SHREG_PARITY_EN
    logic parity_q;

    // computed from q_d so parity always describes the q that is registered alongside it
    always_ff @(posedge clk) begin
        if (rst) begin
            parity_q <= ^RST_VAL;
        end else begin
            parity_q <= ^q_d;
        end
    end

    assign parity = parity_q;
`endif

    assign q        = q_q;
    assign sout_lsb = q_q[0];
    assign sout_msb = q_q[WIDTH-1];
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed self-checking bench for univ_shift_reg (WIDTH=8, RST_VAL=0).
module tb_univ_shift_reg;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [2:0] mode;
    logic [7:0] d;
    logic       sin_msb;
    logic       sin_lsb;
    logic [7:0] q;
    logic       sout_lsb;
    logic       sout_msb;
    logic       busy;
    logic       done;
`ifdef SHREG_PARITY_EN
    logic       parity;
`endif

    int n_total = 0;
    int n_pass  = 0;
    int busy_cycles;

    univ_shift_reg #(.WIDTH(8), .RST_VAL(8'h00)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .mode     (mode),
        .d        (d),
        .sin_msb  (sin_msb),
        .sin_lsb  (sin_lsb),
        .q        (q),
        .sout_lsb (sout_lsb),
        .sout_msb (sout_msb),
        .busy     (busy),
        .done     (done)
`ifdef SHREG_PARITY_EN
        ,
        .parity   (parity)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
            $error("check %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [7:0] word;

        rst = 1'b1; en = 1'b1; mode = 3'b101; d = 8'hFF; sin_msb = 1'b0; sin_lsb = 1'b0;
        tick(); tick();
        chk("rst_q", q, 8'h00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_sout_lsb", sout_lsb, 1'b0);
`ifdef SHREG_PARITY_EN
        chk("rst_parity", parity, 1'b0);
`endif

        rst = 1'b0;
        tick();
        chk("load_ff", q, 8'hFF);
        chk("load_ff_msb", sout_msb, 1'b1);

        d = 8'hB4; tick();
        chk("load_b4", q, 8'hB4);
        mode = 3'b001; sin_msb = 1'b1;
        tick(); tick(); tick();
        chk("shr3", q, 8'hF6);
        mode = 3'b100;
        tick(); tick();
        chk("rotl2", q, 8'hDB);

        mode = 3'b101; d = 8'h81; tick();
        mode = 3'b011; tick();
        chk("rotr", q, 8'hC0);

        mode = 3'b101; d = 8'h81; tick();
        mode = 3'b010; sin_lsb = 1'b0; tick();
        chk("shl", q, 8'h02);
        mode = 3'b111; tick();
        chk("clear", q, 8'h00);
        mode = 3'b000;
        tick(); tick(); tick(); tick();
        chk("hold4", q, 8'h00);

        // plain serialise of A5
        word = 8'hA5; sin_msb = 1'b0;
        mode = 3'b110; d = word; tick();
        mode = 3'b000;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("ser_bit%0d", i), sout_lsb, word[i]);
            chk($sformatf("ser_busy%0d", i), busy, 1'b1);
            chk($sformatf("ser_nodone%0d", i), done, 1'b0);
            tick();
        end
        chk("ser_done", done, 1'b1);
        chk("ser_done_busy", busy, 1'b0);
        chk("ser_done_q", q, 8'h00);
        en = 1'b0; tick();
        chk("done_clears_en0", done, 1'b0);
        en = 1'b1;

        // serialise with a 3-cycle enable gap after the 2nd bit
        mode = 3'b110; d = word; tick();
        mode = 3'b000;
        busy_cycles = 0;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("gap_bit%0d", i), sout_lsb, word[i]);
            if (busy) busy_cycles++;
            if (i == 1) begin
                en = 1'b0;
                for (int j = 0; j < 3; j++) begin
                    tick();
                    chk($sformatf("gap_hold%0d", j), sout_lsb, 1'b0);
                    chk($sformatf("gap_nodone%0d", j), done, 1'b0);
                    if (busy) busy_cycles++;
                end
                en = 1'b1;
            end
            tick();
        end
        chk("gap_busy_cycles", busy_cycles, 11);
        chk("gap_done", done, 1'b1);

        // restart in the done cycle, then reset mid-operation
        mode = 3'b110; d = 8'h3C; tick();
        chk("restart_q", q, 8'h3C);
        chk("restart_busy", busy, 1'b1);
        chk("restart_nodone", done, 1'b0);
        mode = 3'b000;
        tick(); tick(); tick();
        chk("mid_q", q, 8'h07);
        rst = 1'b1; tick();
        rst = 1'b0;
        chk("abort_rst_q", q, 8'h00);
        chk("abort_rst_busy", busy, 1'b0);
        for (int i = 0; i < 10; i++) begin
            if (done !== 1'b0) chk("abort_rst_nodone", done, 1'b0);
            tick();
        end
        chk("abort_rst_done_end", done, 1'b0);

        // clear during SHIFT aborts
        mode = 3'b110; d = 8'h3C; tick();
        mode = 3'b000; tick(); tick(); tick();
        mode = 3'b111; tick();
        mode = 3'b000;
        chk("abort_clr_q", q, 8'h00);
        chk("abort_clr_busy", busy, 1'b0);
        chk("abort_clr_done", done, 1'b0);
        for (int i = 0; i < 10; i++) begin
            if (done !== 1'b0) chk("abort_clr_nodone", done, 1'b0);
            if (busy !== 1'b0) chk("abort_clr_idle", busy, 1'b0);
            tick();
        end
        mode = 3'b001; sin_msb = 1'b1; tick();
        chk("idle_after_abort", q, 8'h80);

`ifdef SHREG_PARITY_EN
        mode = 3'b101; d = 8'h07; tick();
        chk("parity_07", parity, 1'b1);
        d = 8'h03; tick();
        chk("parity_03", parity, 1'b0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
